// File: rtl/input_stream_sequencer.sv
// Input-side execution sequencer for the CGRA.
// Latches per-stream read configuration on execute, issues word reads for all
// streams over one shared memory port with round-robin arbitration, and routes
// the in-order responses back to the requesting node.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   execute_i, abort_i            start / abort pulses
//   cfg_addr_i/size_i/stride_i    per-stream base address, word count, byte stride
//   node_ready_i                  per-node "can take one more word"
//   mem_req_o/addr_o/gnt_i        read request channel
//   mem_rvalid_i/rdata_i          in-order read responses
//   node_valid_o/data_o           per-node data strobe and payload
//   busy_o, done_o, cycle_count_o status
module input_stream_sequencer #(
    parameter int unsigned INPUT_NODES_NUM = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              execute_i,
    input  logic                              abort_i,
    input  logic [INPUT_NODES_NUM-1:0][31:0]  cfg_addr_i,
    input  logic [INPUT_NODES_NUM-1:0][15:0]  cfg_size_i,
    input  logic [INPUT_NODES_NUM-1:0][15:0]  cfg_stride_i,
    input  logic [INPUT_NODES_NUM-1:0]        node_ready_i,
    output logic                              mem_req_o,
    output logic [31:0]                       mem_addr_o,
    input  logic                              mem_gnt_i,
    input  logic                              mem_rvalid_i,
    input  logic [31:0]                       mem_rdata_i,
    output logic [INPUT_NODES_NUM-1:0]        node_valid_o,
    output logic [INPUT_NODES_NUM-1:0][31:0]  node_data_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [31:0]                       cycle_count_o
);

    localparam int unsigned IDX_W = (INPUT_NODES_NUM > 1) ? $clog2(INPUT_NODES_NUM) : 1;
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   done_d;
    logic   start_run;

    logic [INPUT_NODES_NUM-1:0][31:0] cur_addr_q;
    logic [INPUT_NODES_NUM-1:0][15:0] size_q;
    logic [INPUT_NODES_NUM-1:0][15:0] stride_q;
    logic [INPUT_NODES_NUM-1:0][15:0] issued_q;

    logic [IDX_W-1:0] ptr_q;
    logic             pend_q;
    logic [IDX_W-1:0] pend_idx_q;

    logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] fifo_q;
    logic [PTR_W-1:0]                      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]                      out_cnt_q;

    logic        busy_q, done_q;
    logic [31:0] cycle_cnt_q;

    logic [INPUT_NODES_NUM-1:0] elig;
    logic                       fifo_full;
    logic                       all_issued;
    logic                       arb_found;
    logic [IDX_W-1:0]           arb_idx;
    logic [IDX_W-1:0]           sel_idx;
    logic                       hs;
    logic                       pop;
    logic [IDX_W-1:0]           pop_idx;

    assign fifo_full = (out_cnt_q == CNT_W'(MAX_OUTSTANDING));

    // Per-stream eligibility and completion
    always_comb begin
        elig       = '0;
        all_issued = 1'b1;
        for (int unsigned n = 0; n < INPUT_NODES_NUM; n++) begin
            elig[n] = (issued_q[n] < size_q[n]) && node_ready_i[n] && !fifo_full;
            if (issued_q[n] != size_q[n]) begin
                all_issued = 1'b0;
            end
        end
    end

    // Round-robin search starting at the priority pointer
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int unsigned i = 0; i < INPUT_NODES_NUM; i++) begin
            if (!arb_found && elig[IDX_W'((32'(ptr_q) + i) % INPUT_NODES_NUM)]) begin
                arb_found = 1'b1;
                arb_idx   = IDX_W'((32'(ptr_q) + i) % INPUT_NODES_NUM);
            end
        end
    end

    // A pending ungranted request freezes selection until it is accepted
    assign sel_idx    = pend_q ? pend_idx_q : arb_idx;
    assign mem_req_o  = (state_q == S_RUN) && (pend_q || arb_found);
    assign mem_addr_o = mem_req_o ? cur_addr_q[sel_idx] : 32'd0;
    assign hs         = mem_req_o && mem_gnt_i;

    // Responses with an empty ID FIFO are dropped
    assign pop     = mem_rvalid_i && (out_cnt_q != '0);
    assign pop_idx = fifo_q[rd_ptr_q];

    // Response routing; suppressed while draining after an abort
    always_comb begin
        node_valid_o = '0;
        node_data_o  = '0;
        if (pop && (state_q == S_RUN)) begin
            node_valid_o[pop_idx] = 1'b1;
            node_data_o[pop_idx]  = mem_rdata_i;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        start_run = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (execute_i) begin
                    state_d   = S_RUN;
                    start_run = 1'b1;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_DRAIN;
                end else if (all_issued && (out_cnt_q == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
            if (start_run) begin
                cycle_cnt_q <= '0;
            end else if ((state_q == S_RUN) && (cycle_cnt_q != '1)) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
        end
    end

    // Stream configuration and issue tracking; running address avoids a multiplier
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_addr_q <= '0;
            size_q     <= '0;
            stride_q   <= '0;
            issued_q   <= '0;
        end else begin
            for (int unsigned n = 0; n < INPUT_NODES_NUM; n++) begin
                if (start_run) begin
                    cur_addr_q[n] <= cfg_addr_i[n];
                    size_q[n]     <= cfg_size_i[n];
                    stride_q[n]   <= cfg_stride_i[n];
                    issued_q[n]   <= '0;
                end else if (hs && (sel_idx == IDX_W'(n))) begin
                    cur_addr_q[n] <= cur_addr_q[n] + 32'(stride_q[n]);
                    issued_q[n]   <= issued_q[n] + 16'd1;
                end
            end
        end
    end

    // Arbitration pointer and pending-request hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            if (hs) begin
                ptr_q <= (sel_idx == IDX_W'(INPUT_NODES_NUM - 1)) ? '0 : sel_idx + IDX_W'(1);
            end
            pend_q <= mem_req_o && !mem_gnt_i && (state_d == S_RUN);
            if (mem_req_o && !mem_gnt_i) begin
                pend_idx_q <= sel_idx;
            end
        end
    end

    // Response-ID FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            if (hs) begin
                fifo_q[wr_ptr_q] <= sel_idx;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            out_cnt_q <= out_cnt_q + CNT_W'(hs) - CNT_W'(pop);
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign cycle_count_o = cycle_cnt_q;

endmodule

// File: tb/tb_input_stream_sequencer.sv
// Self-checking bench for input_stream_sequencer: a behavioural model plus a
// memory responder, directed scenarios and randomized runs.
module tb_input_stream_sequencer;

    localparam int N       = 4;
    localparam int MAXO    = 4;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                execute_i;
    logic                abort_i;
    logic [N-1:0][31:0]  cfg_addr_i;
    logic [N-1:0][15:0]  cfg_size_i;
    logic [N-1:0][15:0]  cfg_stride_i;
    logic [N-1:0]        node_ready_i;
    logic                mem_req_o;
    logic [31:0]         mem_addr_o;
    logic                mem_gnt_i;
    logic                mem_rvalid_i;
    logic [31:0]         mem_rdata_i;
    logic [N-1:0]        node_valid_o;
    logic [N-1:0][31:0]  node_data_o;
    logic                busy_o;
    logic                done_o;
    logic [31:0]         cycle_count_o;

    always #5 clk_i = ~clk_i;

    input_stream_sequencer #(.INPUT_NODES_NUM(N), .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .execute_i(execute_i), .abort_i(abort_i),
        .cfg_addr_i(cfg_addr_i), .cfg_size_i(cfg_size_i), .cfg_stride_i(cfg_stride_i),
        .node_ready_i(node_ready_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .node_valid_o(node_valid_o), .node_data_o(node_data_o), .busy_o(busy_o),
        .done_o(done_o), .cycle_count_o(cycle_count_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    int        mstate;
    int        m_size[N];
    int        m_stride[N];
    int        m_issued[N];
    bit [31:0] m_base[N];
    int        m_ptr, m_pend, m_pidx;
    int        m_q[$];
    bit [31:0] m_cnt;
    bit        m_busy, m_done;

    // memory responder
    bit [31:0] memq_addr[$];
    int        memq_due[$];
    int        cyc = 0;
    int        gnt_pct = 100, rv_pct = 100, lat_min = 1, lat_max = 1, gnt_low_cnt = 0;
    bit        ready_rand = 1'b0, spurious = 1'b0;

    // observation logs
    int        log_idx[$];
    bit [31:0] log_addr[$];
    int        nv_cnt[N];
    int        done_cnt;
    bit        rv_seen;
    int        req_before_rv;
    bit        last_req;
    bit [31:0] last_addr;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mstate = S_IDLE; m_ptr = 0; m_pend = 0; m_pidx = 0;
        m_q.delete(); m_cnt = '0; m_busy = 1'b0; m_done = 1'b0;
        for (int n = 0; n < N; n++) begin
            m_issued[n] = 0; m_size[n] = 0; m_stride[n] = 0; m_base[n] = '0;
        end
    endtask

    task automatic clear_logs();
        log_idx.delete(); log_addr.delete();
        for (int n = 0; n < N; n++) nv_cnt[n] = 0;
        done_cnt = 0; rv_seen = 1'b0; req_before_rv = 0;
    endtask

    task automatic set_cfg(input int n, input bit [31:0] a, input int sz, input int st);
        cfg_addr_i[n]   = a;
        cfg_size_i[n]   = 16'(sz);
        cfg_stride_i[n] = 16'(st);
    endtask

    function automatic int count_idx(input int k);
        int c = 0;
        foreach (log_idx[i]) if (log_idx[i] == k) c++;
        return c;
    endfunction

    // One clock cycle: drive memory side, compare against model, advance model
    task automatic tick();
        bit           e_req;
        int           e_sel;
        bit [31:0]    e_addr;
        bit           e_pop;
        int           e_m;
        logic [N-1:0] e_nv;
        bit           hs;
        bit           all_done;
        bit           rv_from_q;
        int           qsz0;

        if (ready_rand) node_ready_i = N'($urandom);
        if (gnt_low_cnt > 0) begin
            mem_gnt_i = 1'b0;
            gnt_low_cnt--;
        end else begin
            mem_gnt_i = ($urandom_range(99) < gnt_pct);
        end
        rv_from_q = 1'b0;
        if (memq_addr.size() > 0 && memq_due[0] <= cyc && $urandom_range(99) < rv_pct) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = memq_addr[0]; rv_from_q = 1'b1;
        end else if (spurious) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = $urandom;
        end else begin
            mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
        end
        #3;

        e_req = 1'b0; e_sel = 0;
        if (mstate == S_RUN) begin
            if (m_pend != 0) begin
                e_req = 1'b1; e_sel = m_pidx;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int n;
                    n = (m_ptr + i) % N;
                    if (!e_req && m_issued[n] < m_size[n] && node_ready_i[n] && m_q.size() < MAXO) begin
                        e_req = 1'b1; e_sel = n;
                    end
                end
            end
        end
        e_addr = 32'(longint'(m_base[e_sel]) + longint'(m_issued[e_sel]) * longint'(m_stride[e_sel]));
        e_pop  = mem_rvalid_i && (m_q.size() > 0);
        e_m    = e_pop ? m_q[0] : 0;
        e_nv   = '0;
        if (e_pop && mstate == S_RUN) e_nv[e_m] = 1'b1;

        chk("mem_req", mem_req_o, e_req);
        if (e_req) chk("mem_addr", mem_addr_o, e_addr);
        chk("node_valid", node_valid_o, e_nv);
        if (e_nv != '0) chk("node_data", node_data_o[e_m], mem_rdata_i);
        chk("busy", busy_o, m_busy);
        chk("done", done_o, m_done);
        chk("cycle_count", cycle_count_o, m_cnt);

        last_req  = mem_req_o;
        last_addr = mem_addr_o;
        if (mem_req_o && mem_gnt_i) log_addr.push_back(mem_addr_o);
        if (done_o) done_cnt++;
        for (int n = 0; n < N; n++) if (node_valid_o[n]) nv_cnt[n]++;
        if (mem_rvalid_i) rv_seen = 1'b1;
        if (mem_req_o && !rv_seen) req_before_rv++;

        hs = e_req && mem_gnt_i;
        if (rv_from_q) begin
            void'(memq_addr.pop_front());
            void'(memq_due.pop_front());
        end
        if (hs) begin
            memq_addr.push_back(e_addr);
            memq_due.push_back(cyc + $urandom_range(lat_max, lat_min));
            log_idx.push_back(e_sel);
        end

        all_done = 1'b1;
        for (int n = 0; n < N; n++) if (m_issued[n] != m_size[n]) all_done = 1'b0;
        qsz0 = m_q.size();
        if (e_pop) void'(m_q.pop_front());
        if (hs) begin
            m_q.push_back(e_sel);
            m_issued[e_sel]++;
            m_ptr  = (e_sel + 1) % N;
            m_pend = 0;
        end else if (e_req) begin
            m_pend = 1; m_pidx = e_sel;
        end
        m_done = 1'b0;
        case (mstate)
            S_IDLE: if (execute_i) begin
                for (int n = 0; n < N; n++) begin
                    m_base[n]   = cfg_addr_i[n];
                    m_size[n]   = int'(cfg_size_i[n]);
                    m_stride[n] = int'(cfg_stride_i[n]);
                    m_issued[n] = 0;
                end
                m_cnt = '0; m_pend = 0; mstate = S_RUN;
            end
            S_RUN: begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (abort_i) begin
                    mstate = S_DRAIN; m_pend = 0;
                end else if (all_done && qsz0 == 0) begin
                    mstate = S_IDLE; m_done = 1'b1;
                end
            end
            default: if (qsz0 == 0) mstate = S_IDLE;
        endcase
        m_busy = (mstate != S_IDLE);

        cyc++;
        @(posedge clk_i);
        #1;
        execute_i = 1'b0;
        abort_i   = 1'b0;
    endtask

    task automatic run_until_idle(input int bound);
        int k = 0;
        while (mstate != S_IDLE && k < bound) begin
            tick();
            k++;
        end
        chk("run_timeout_idle", 128'(mstate), 128'(S_IDLE));
        tick();
    endtask

    // Asynchronous reset asserted mid-cycle
    task automatic do_reset();
        rst_ni = 1'b0;
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_req", mem_req_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_count", cycle_count_o, 32'd0);
        chk("rst_valid", node_valid_o, '0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic flush_mem();
        int k = 0;
        while (memq_addr.size() > 0 && k < 200) begin
            tick();
            k++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; execute_i = 1'b0; abort_i = 1'b0;
        cfg_addr_i = '0; cfg_size_i = '0; cfg_stride_i = '0;
        node_ready_i = '1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_reset();
        clear_logs();
        #3;
        chk("reset_req", mem_req_o, 1'b0);
        chk("reset_addr", mem_addr_o, 32'd0);
        chk("reset_valid", node_valid_o, '0);
        chk("reset_data", node_data_o, '0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_count", cycle_count_o, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // single stream, gnt always, one-cycle response
        for (int n = 0; n < N; n++) set_cfg(n, $urandom, 0, 4);
        set_cfg(0, 32'h8000_0000, 80, 4);
        clear_logs();
        execute_i = 1'b1; tick();
        run_until_idle(300);
        chk("single_nreq", 128'(log_addr.size()), 128'(80));
        if (log_addr.size() == 80) begin
            chk("single_first", log_addr[0], 32'h8000_0000);
            chk("single_last", log_addr[79], 32'h8000_013C);
        end
        chk("single_strobes", 128'(nv_cnt[0]), 128'(80));
        chk("single_done", 128'(done_cnt), 128'(1));
        chk("single_cycles", cycle_count_o, 32'd82);

        // four streams, round-robin order from reset pointer
        do_reset();
        for (int n = 0; n < N; n++) set_cfg(n, 32'(n * 32'h1000), 3, 4);
        clear_logs();
        execute_i = 1'b1; tick();
        run_until_idle(200);
        chk("rr_ngrants", 128'(log_idx.size()), 128'(12));
        if (log_idx.size() == 12)
            for (int i = 0; i < 12; i++) chk("rr_order", 128'(log_idx[i]), 128'(i % 4));
        if (log_addr.size() == 12) chk("rr_addr1", log_addr[1], 32'h0000_1000);
        for (int n = 0; n < N; n++) chk("rr_strobes", 128'(nv_cnt[n]), 128'(3));

        // backpressure on node 1, then grant stall
        for (int n = 0; n < N; n++) set_cfg(n, 32'(32'h2000_0000 + n * 32'h100), 6, 4);
        clear_logs();
        node_ready_i = 4'b1101;
        execute_i = 1'b1; tick();
        for (int i = 0; i < 10; i++) tick();
        chk("bp_grants", 128'(log_idx.size()), 128'(10));
        chk("bp_skip1", 128'(count_idx(1)), 128'(0));
        node_ready_i = '1;
        gnt_low_cnt = 5;
        begin
            bit [31:0] held;
            tick();
            held = last_addr;
            chk("stall_req", last_req, 1'b1);
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("stall_req", last_req, 1'b1);
                chk("stall_addr", last_addr, held);
            end
        end
        run_until_idle(300);
        chk("bp_resume1", 128'(count_idx(1)), 128'(6));
        chk("bp_total", 128'(log_idx.size()), 128'(24));

        // outstanding limit with slow responses
        for (int n = 0; n < N; n++) set_cfg(n, 32'(32'h3000_0000 + n * 32'h40), 2, 4);
        clear_logs();
        lat_min = 10; lat_max = 10;
        execute_i = 1'b1; tick();
        run_until_idle(300);
        chk("outst_req_before_rv", 128'(req_before_rv), 128'(4));
        chk("outst_done", 128'(done_cnt), 128'(1));

        // abort with three outstanding
        for (int n = 0; n < N; n++) set_cfg(n, 32'h0, 0, 4);
        set_cfg(0, 32'h5000_0000, 10, 4);
        clear_logs();
        lat_min = 8; lat_max = 8;
        execute_i = 1'b1; tick();
        for (int i = 0; i < 3; i++) tick();
        chk("abort_outst", 128'(m_q.size()), 128'(3));
        abort_i = 1'b1; gnt_low_cnt = 1; tick();
        chk("abort_req_drop", mem_req_o, 1'b0);
        chk("abort_busy", busy_o, 1'b1);
        begin
            int nv_before;
            nv_before = nv_cnt[0];
            run_until_idle(100);
            chk("abort_no_strobe", 128'(nv_cnt[0]), 128'(nv_before));
        end
        chk("abort_no_done", 128'(done_cnt), 128'(0));
        chk("abort_idle", busy_o, 1'b0);
        lat_min = 1; lat_max = 1;
        set_cfg(0, 32'h4000, 2, 4);
        clear_logs();
        execute_i = 1'b1; tick();
        run_until_idle(50);
        chk("restart_done", 128'(done_cnt), 128'(1));
        chk("restart_strobes", 128'(nv_cnt[0]), 128'(2));

        // address wrap, execute during RUN ignored
        set_cfg(0, 32'hFFFF_FFFC, 2, 4);
        clear_logs();
        execute_i = 1'b1; tick();
        set_cfg(0, 32'h1234_0000, 5, 8);
        execute_i = 1'b1; tick();
        run_until_idle(50);
        chk("wrap_n", 128'(log_addr.size()), 128'(2));
        if (log_addr.size() == 2) begin
            chk("wrap_a0", log_addr[0], 32'hFFFF_FFFC);
            chk("wrap_a1", log_addr[1], 32'h0000_0000);
        end

        // all sizes zero; stray response while idle
        for (int n = 0; n < N; n++) set_cfg(n, $urandom, 0, 4);
        clear_logs();
        execute_i = 1'b1; tick();
        tick();
        tick();
        chk("zero_done", 128'(done_cnt), 128'(1));
        chk("zero_noreq", 128'(log_addr.size()), 128'(0));
        chk("zero_cycles", cycle_count_o, 32'd1);
        spurious = 1'b1; tick(); spurious = 1'b0;
        chk("stray_rvalid", node_valid_o, '0);

        // randomized runs
        gnt_pct = 70; rv_pct = 70; lat_min = 1; lat_max = 5; ready_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            bit was_reset;
            int k;
            was_reset = 1'b0;
            for (int n = 0; n < N; n++)
                set_cfg(n, $urandom, ($urandom_range(3) == 0) ? 0 : int'($urandom_range(12, 1)),
                        ($urandom_range(1) == 1) ? int'($urandom_range(65535)) : int'(4 * $urandom_range(4)));
            clear_logs();
            execute_i = 1'b1; tick();
            k = 0;
            while (mstate != S_IDLE && k < 1500) begin
                if ($urandom_range(19) == 0) execute_i = 1'b1;
                if ($urandom_range(9) == 0) cfg_size_i[$urandom_range(N - 1)] = 16'($urandom);
                if (r == 3 && k == 15 && mstate == S_RUN) abort_i = 1'b1;
                if (r == 5 && k == 12) begin
                    do_reset();
                    flush_mem();
                    was_reset = 1'b1;
                    break;
                end
                tick();
                k++;
            end
            if (!was_reset) begin
                chk("rand_timeout_idle", 128'(mstate), 128'(S_IDLE));
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
